// File: rtl/pattern_writer.sv
// Frame pattern generator: on each prescaler tick it streams one full frame
// of 2^ADDR_W pixel words into a RAM write port, honouring back-pressure.
// Patterns: SOLID, ROTATE (top 6-bit field rotated by phase), CHECKER, RAMP.
module pattern_writer #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int PRESCALE = 374_999,
  parameter int CHK_BIT  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_color_a,
  input  logic [DATA_W-1:0] i_color_b,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_w_enable,
  input  logic              i_w_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE);
  localparam int SUM_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_ROTATE  = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_RAMP    = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]        state;
  logic [PRE_W-1:0]  presc_cnt;
  logic              tick;
  logic              start;
  logic              xfer;
  logic              last_xfer;
  logic [1:0]        phase;
  logic [7:0]        frame_cnt;
  logic [1:0]        cfg_mode_p0;
  logic [DATA_W-1:0] cfg_color_a_p0;
  logic [DATA_W-1:0] cfg_color_b_p0;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] w_addr_p1;
  logic [DATA_W-1:0] w_data_p1;
  logic              vld_p1;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  // Pixel word for one address given the latched frame configuration.
  function automatic logic [DATA_W-1:0] pixel_word(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] ca,
    input logic [DATA_W-1:0] cb,
    input logic [ADDR_W-1:0] addr,
    input logic [1:0]        ph,
    input logic [7:0]        fc
  );
    logic [DATA_W-1:0] r;
    logic [5:0]        fld;
    logic [SUM_W-1:0]  sum;
    r   = ca;
    fld = ca[DATA_W-1 -: 6];
    sum = SUM_W'(addr) + SUM_W'(fc);
    case (mode)
      MODE_SOLID: r = ca;
      MODE_ROTATE: begin
        case (ph)
          2'd1:    fld = {fld[1:0], fld[5:2]};
          2'd2:    fld = {fld[3:0], fld[5:4]};
          default: fld = ca[DATA_W-1 -: 6];
        endcase
        r[DATA_W-1 -: 6] = fld;
      end
      MODE_CHECKER: r = (addr[CHK_BIT] ^ ph[0]) ? cb : ca;
      MODE_RAMP:    r = DATA_W'(sum);
      default:      r = ca;
    endcase
    return r;
  endfunction

  assign tick      = i_enable && (presc_cnt == '0);
  assign start     = (state == ST_IDLE) && tick;
  assign xfer      = vld_p1 && i_w_ready;
  assign last_xfer = xfer && (w_addr_p1 == ADDR_LAST);
  assign next_addr = w_addr_p1 + ADDR_W'(1);

  // Frame tick prescaler: counts down while enabled, reloads after hitting zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_cnt <= PRE_LOAD;
    end else if (i_enable) begin
      if (presc_cnt == '0) presc_cnt <= PRE_LOAD;
      else                 presc_cnt <= presc_cnt - PRE_W'(1);
    end
  end

  // Frame configuration captured at frame start; held for the whole frame.
  always_ff @(posedge i_clk) begin
    if (start) begin
      cfg_mode_p0    <= i_mode;
      cfg_color_a_p0 <= i_color_a;
      cfg_color_b_p0 <= i_color_b;
    end
  end

  // Control FSM: frame start, end-of-frame bookkeeping, overrun detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      vld_p1     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      phase      <= 2'd0;
      frame_cnt  <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= tick && (state == ST_WRITE);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state  <= ST_WRITE;
            vld_p1 <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (last_xfer) begin
            state      <= ST_IDLE;
            vld_p1     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            phase      <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          vld_p1 <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: address and data advance together on each accepted transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_addr_p1 <= '0;
      w_data_p1 <= '0;
    end else if (start) begin
      w_addr_p1 <= '0;
      w_data_p1 <= pixel_word(i_mode, i_color_a, i_color_b, '0, phase, frame_cnt);
    end else if ((state == ST_WRITE) && xfer && !last_xfer) begin
      w_addr_p1 <= next_addr;
      w_data_p1 <= pixel_word(cfg_mode_p0, cfg_color_a_p0, cfg_color_b_p0,
                              next_addr, phase, frame_cnt);
    end
  end

  assign o_w_addr     = w_addr_p1;
  assign o_w_data     = w_data_p1;
  assign o_w_enable   = vld_p1;
  assign o_busy       = busy;
  assign o_frame_done = frame_done;
  assign o_overrun    = overrun;

endmodule
